riscv_decoder: RTL and testbench



---
 rtl/riscv_decoder.sv | 85 ++++++++
 tb/tb_riscv_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/riscv_decoder.sv
// rtl/riscv_decoder.sv - RV32I instruction field and immediate decoder
//
// Purely combinational decode of one 32-bit RV32I instruction word.
// clk and rst_n are present only so the block fits the core's port pattern.
// They never influence any output.
//
// Ports:
//   clk          in   1   system clock (unused by decode)
//   rst_n        in   1   asynchronous active-low reset (unused by decode)
//   instruction  in  32   raw instruction word
//   opcode       out  7   instruction[6:0]
//   rd           out  5   instruction[11:7]
//   funct3       out  3   instruction[14:12]
//   rs1          out  5   instruction[19:15]
//   rs2          out  5   instruction[24:20]
//   funct7       out  7   instruction[31:25]
//   imm          out 32   immediate for the format selected by opcode

module riscv_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // clk and rst_n are intentionally not part of the decode path.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};

    // Raw field slices, driven for every instruction regardless of format.
    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // Candidate immediates for every format; the opcode picks one below.
    // instruction[31] is always the sign bit, so replicating it sign-extends.
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        imm = 32'h0000_0000;
        case (instruction[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm = imm_i;
            OP_STORE:                            imm = imm_s;
            OP_BRANCH:                           imm = imm_b;
            OP_LUI, OP_AUIPC:                    imm = imm_u;
            OP_JAL:                              imm = imm_j;
            // R-type carries no immediate; unknown opcodes read as zero too.
            OP_REG:                              imm = 32'h0000_0000;
            default:                             imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_riscv_decoder.sv
// tb/tb_riscv_decoder.sv - self-checking bench for riscv_decoder

module tb_riscv_decoder;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (instr 0x%08h)",
                     tag, observed, expected, instruction);
        end
    endtask

    // Reference model: bit fields pulled out arithmetically, immediates
    // assembled by weighted sums and sign-extended by two's-complement wrap.
    function automatic longint field(input logic [31:0] w, input int lo, input int width);
        longint v;
        v = longint'(w);
        return (v / (64'sd1 << lo)) % (64'sd1 << width);
    endfunction

    function automatic logic [31:0] sext(input longint v, input int nbits);
        longint r;
        r = v;
        if (v >= (64'sd1 << (nbits - 1)))
            r = v - (64'sd1 << nbits);
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] w);
        longint op;
        longint v;
        op = field(w, 0, 7);
        case (op)
            64'h13, 64'h03, 64'h67, 64'h73:
                return sext(field(w, 20, 12), 12);
            64'h23: begin
                v = field(w, 25, 7) * 32 + field(w, 7, 5);
                return sext(v, 12);
            end
            64'h63: begin
                v = field(w, 31, 1) * 4096 + field(w, 7, 1) * 2048
                  + field(w, 25, 6) * 32 + field(w, 8, 4) * 2;
                return sext(v, 13);
            end
            64'h37, 64'h17: begin
                v = field(w, 12, 20) * 4096;
                return v[31:0];
            end
            64'h6f: begin
                v = field(w, 31, 1) * (64'sd1 << 20) + field(w, 12, 8) * 4096
                  + field(w, 20, 1) * 2048 + field(w, 21, 10) * 2;
                return sext(v, 21);
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        longint f;
        f = field(instruction, 0, 7);   check_eq({tag, ".opcode"}, {25'd0, opcode}, f[31:0]);
        f = field(instruction, 7, 5);   check_eq({tag, ".rd"},     {27'd0, rd},     f[31:0]);
        f = field(instruction, 12, 3);  check_eq({tag, ".funct3"}, {29'd0, funct3}, f[31:0]);
        f = field(instruction, 15, 5);  check_eq({tag, ".rs1"},    {27'd0, rs1},    f[31:0]);
        f = field(instruction, 20, 5);  check_eq({tag, ".rs2"},    {27'd0, rs2},    f[31:0]);
        f = field(instruction, 25, 7);  check_eq({tag, ".funct7"}, {25'd0, funct7}, f[31:0]);
        check_eq({tag, ".imm"}, imm, model_imm(instruction));
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [6:0]  exp_op;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t dir_vecs[$];

    logic [6:0] op_pool[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    initial begin
        clk_run     = 1'b0;
        rst_n       = 1'b0;
        instruction = 32'h0;

        dir_vecs.push_back('{"sra",   32'h4030d133, 7'b0110011, 32'h0});
        dir_vecs.push_back('{"addi",  32'h01710193, 7'b0010011, 32'd23});
        dir_vecs.push_back('{"lb",    32'hfe208103, 7'b0000011, 32'hffffffe2});
        dir_vecs.push_back('{"jalr",  32'h00008167, 7'b1100111, 32'h0});
        dir_vecs.push_back('{"sw",    32'h003120a3, 7'b0100011, 32'd1});
        dir_vecs.push_back('{"beq",   32'h00310163, 7'b1100011, 32'd2});
        dir_vecs.push_back('{"lui",   32'h00028137, 7'b0110111, 32'h00028000});
        dir_vecs.push_back('{"jal",   32'h014001ef, 7'b1101111, 32'd20});
        dir_vecs.push_back('{"beqm4", 32'hfe000ee3, 7'b1100011, 32'hfffffffc});
        dir_vecs.push_back('{"jalm8", 32'hff9ff06f, 7'b1101111, 32'hfffffff8});
        dir_vecs.push_back('{"unk",   32'h1234567f, 7'b1111111, 32'h0});

        // Directed vectors with clk stopped, under both reset levels.
        for (int r = 0; r < 2; r++) begin
            rst_n = (r == 1);
            foreach (dir_vecs[i]) begin
                instruction = dir_vecs[i].instr;
                #1;
                check_eq({dir_vecs[i].name, ".op_const"}, {25'd0, opcode},
                         {25'd0, dir_vecs[i].exp_op});
                check_eq({dir_vecs[i].name, ".imm_const"}, imm, dir_vecs[i].exp_imm);
                check_all(dir_vecs[i].name);
            end
        end

        // Spot field values called out for SRA.
        instruction = 32'h4030d133;
        #1;
        check_eq("sra.rd2",    {27'd0, rd},     32'd2);
        check_eq("sra.f3",     {29'd0, funct3}, 32'd5);
        check_eq("sra.rs1",    {27'd0, rs1},    32'd1);
        check_eq("sra.rs2",    {27'd0, rs2},    32'd3);
        check_eq("sra.funct7", {25'd0, funct7}, 32'h20);

        // Reset edges must not disturb outputs.
        instruction = 32'hfe208103;
        rst_n = 1'b0; #1;
        check_eq("rst_assert.imm", imm, 32'hffffffe2);
        rst_n = 1'b1; #1;
        check_eq("rst_release.imm", imm, 32'hffffffe2);

        // Randomized sweep with the clock running and reset wiggling.
        clk_run = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            instruction = $urandom;
            if ($urandom_range(0, 3) != 0)
                instruction[6:0] = op_pool[$urandom_range(0, 9)];
            rst_n = ($urandom_range(0, 7) != 0);
            #1;
            check_all("rand");
        end
        clk_run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
